// File: rtl/caf_sweep_ctrl_pkg.sv
// Shared definitions for the CAF sweep sequencer.
// Holds the sequencer state encodings and the index-width helper that sizes
// the address, lag and drain-counter fields.
package caf_sweep_ctrl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SWEEP = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Index width for a range of n values; never zero so a single-entry range
  // still gets a real (constant-zero) field.
  function automatic int unsigned idx_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/caf_tag_delay.sv
// Fixed-latency shift register that carries the per-request tag payload
// ({valid, first, last, lag}) alongside the buffer read latency.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   i_flush    synchronous flush of every stage (abort)
//   i_data     payload for the request issued this cycle
//   o_data     payload issued DEPTH cycles ago
module caf_tag_delay #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_pipe [DEPTH];

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_pipe[i] <= '0;
      end
    end else begin
      r_pipe[0] <= i_data;
      for (int i = 1; i < int'(DEPTH); i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign o_data = r_pipe[DEPTH-1];

endmodule

// File: rtl/caf_sweep_ctrl.sv
// CAF correlation sweep sequencer.
// For every lag, walks the reference buffer (iter) and the capture buffer
// (lag + iter) in lock-step, issuing one read request per handshake, and
// emits first/last/lag tags aligned with the returning read data.
// Ports:
//   clk, rst               clock and synchronous active-high reset
//   start, abort           begin a sweep (idle only) / stop immediately
//   busy                   high outside IDLE
//   m_axi_cap_rvalid       read request to both buffers
//   s_axi_cap_rready       buffers accept a request
//   s_axis_freq_tready     frequency-shifter bank can take a sample
//   m_axi_cap_raddr        capture address, lag + iter
//   m_axi_ref_raddr        reference address, iter
//   tag_valid/first/last   read data for a fired request is present
//   tag_lag                lag of that sample
//   sweep_done             one-cycle pulse at the end of a full sweep
module caf_sweep_ctrl
  import caf_sweep_ctrl_pkg::*;
#(
  parameter int unsigned CAP_LEN        = 1024,
  parameter int unsigned REF_LEN        = 256,
  parameter int unsigned NUM_LAGS       = CAP_LEN - REF_LEN + 1,
  parameter int unsigned CAP_INDEX_BITS = idx_bits(CAP_LEN),
  parameter int unsigned REF_INDEX_BITS = idx_bits(REF_LEN),
  parameter int unsigned LAG_BITS       = idx_bits(NUM_LAGS),
  parameter int unsigned RD_LAT         = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  output logic                      busy,
  output logic                      m_axi_cap_rvalid,
  input  logic                      s_axi_cap_rready,
  input  logic                      s_axis_freq_tready,
  output logic [CAP_INDEX_BITS-1:0] m_axi_cap_raddr,
  output logic [REF_INDEX_BITS-1:0] m_axi_ref_raddr,
  output logic                      tag_valid,
  output logic                      tag_first,
  output logic                      tag_last,
  output logic [LAG_BITS-1:0]       tag_lag,
  output logic                      sweep_done
);

  localparam int unsigned DRAIN_BITS = idx_bits(RD_LAT);
  localparam int unsigned TAG_W      = LAG_BITS + 3;

  logic [1:0]                r_state;
  logic [1:0]                w_state_d;
  logic [REF_INDEX_BITS-1:0] r_iter;
  logic [REF_INDEX_BITS-1:0] w_iter_d;
  logic [LAG_BITS-1:0]       r_lag;
  logic [LAG_BITS-1:0]       w_lag_d;
  logic [DRAIN_BITS-1:0]     r_drain;
  logic [DRAIN_BITS-1:0]     w_drain_d;
  logic                      r_busy;
  logic                      r_rvalid;
  logic                      r_done;
  logic [CAP_INDEX_BITS-1:0] r_cap_addr;

  logic                      w_fire;
  logic                      w_iter_end;
  logic                      w_lag_end;
  logic [TAG_W-1:0]          w_tag_in;
  logic [TAG_W-1:0]          w_tag_out;

  assign w_fire     = r_rvalid & s_axi_cap_rready & s_axis_freq_tready;
  assign w_iter_end = (r_iter == REF_INDEX_BITS'(REF_LEN - 1));
  assign w_lag_end  = (r_lag == LAG_BITS'(NUM_LAGS - 1));

  always_comb begin
    w_state_d = r_state;
    w_iter_d  = r_iter;
    w_lag_d   = r_lag;
    w_drain_d = r_drain;
    if (abort) begin
      // Abort beats start, fire and drain alike.
      w_state_d = ST_IDLE;
      w_iter_d  = '0;
      w_lag_d   = '0;
      w_drain_d = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            w_state_d = ST_SWEEP;
            w_iter_d  = '0;
            w_lag_d   = '0;
          end
        end
        ST_SWEEP: begin
          if (w_fire) begin
            if (!w_iter_end) begin
              w_iter_d = r_iter + 1'b1;
            end else begin
              w_iter_d = '0;
              if (w_lag_end) begin
                // Counters return to zero instead of wrapping past the end.
                w_lag_d   = '0;
                w_state_d = ST_DRAIN;
                w_drain_d = DRAIN_BITS'(RD_LAT - 1);
              end else begin
                w_lag_d = r_lag + 1'b1;
              end
            end
          end
        end
        ST_DRAIN: begin
          if (r_drain == '0) begin
            w_state_d = ST_DONE;
          end else begin
            w_drain_d = r_drain - 1'b1;
          end
        end
        ST_DONE: begin
          w_state_d = ST_IDLE;
        end
        default: begin
          w_state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they are registered yet line
  // up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_iter     <= '0;
      r_lag      <= '0;
      r_drain    <= '0;
      r_busy     <= 1'b0;
      r_rvalid   <= 1'b0;
      r_done     <= 1'b0;
      r_cap_addr <= '0;
    end else begin
      r_state    <= w_state_d;
      r_iter     <= w_iter_d;
      r_lag      <= w_lag_d;
      r_drain    <= w_drain_d;
      r_busy     <= (w_state_d != ST_IDLE);
      r_rvalid   <= (w_state_d == ST_SWEEP);
      r_done     <= (w_state_d == ST_DONE);
      r_cap_addr <= CAP_INDEX_BITS'(w_lag_d) + CAP_INDEX_BITS'(w_iter_d);
    end
  end

  assign w_tag_in = {w_fire, (r_iter == '0), w_iter_end, r_lag};

  caf_tag_delay #(
    .DEPTH (RD_LAT),
    .WIDTH (TAG_W)
  ) u_tag_delay (
    .clk     (clk),
    .rst     (rst),
    .i_flush (abort),
    .i_data  (w_tag_in),
    .o_data  (w_tag_out)
  );

  assign busy             = r_busy;
  assign m_axi_cap_rvalid = r_rvalid;
  assign m_axi_cap_raddr  = r_cap_addr;
  assign m_axi_ref_raddr  = r_iter;
  assign sweep_done       = r_done;
  assign tag_valid        = w_tag_out[TAG_W-1];
  assign tag_first        = w_tag_out[TAG_W-2];
  assign tag_last         = w_tag_out[TAG_W-3];
  assign tag_lag          = w_tag_out[LAG_BITS-1:0];

endmodule

// File: tb/tb_caf_sweep_ctrl.sv
// Self-checking bench for caf_sweep_ctrl: a transaction-level model (fire
// count -> lag/iter, tag queue with due cycles, done time) checks the main
// instance every cycle; a second instance covers the single-lag case.
module tb_caf_sweep_ctrl;

  localparam int CAP   = 8;
  localparam int REFL  = 4;
  localparam int LAT   = 2;
  localparam int NL    = CAP - REFL + 1;
  localparam int TOTAL = NL * REFL;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       rready = 1'b1;
  logic       tready = 1'b1;
  logic       busy, rvalid, tag_valid, tag_first, tag_last, sweep_done;
  logic [2:0] cap_addr;
  logic [1:0] ref_addr;
  logic [2:0] tag_lag;

  caf_sweep_ctrl #(
    .CAP_LEN (CAP),
    .REF_LEN (REFL),
    .RD_LAT  (LAT)
  ) u_dut (
    .clk                (clk),
    .rst                (rst),
    .start              (start),
    .abort              (abort),
    .busy               (busy),
    .m_axi_cap_rvalid   (rvalid),
    .s_axi_cap_rready   (rready),
    .s_axis_freq_tready (tready),
    .m_axi_cap_raddr    (cap_addr),
    .m_axi_ref_raddr    (ref_addr),
    .tag_valid          (tag_valid),
    .tag_first          (tag_first),
    .tag_last           (tag_last),
    .tag_lag            (tag_lag),
    .sweep_done         (sweep_done)
  );

  // Single-lag instance: CAP_LEN = REF_LEN = 4, RD_LAT = 1.
  logic       start2 = 1'b0;
  logic       busy2, rvalid2, tv2, tf2, tl2, done2;
  logic [1:0] cap2, ref2;
  logic [0:0] lag2;

  caf_sweep_ctrl #(
    .CAP_LEN (4),
    .REF_LEN (4),
    .RD_LAT  (1)
  ) u_dut2 (
    .clk                (clk),
    .rst                (rst),
    .start              (start2),
    .abort              (1'b0),
    .busy               (busy2),
    .m_axi_cap_rvalid   (rvalid2),
    .s_axi_cap_rready   (1'b1),
    .s_axis_freq_tready (1'b1),
    .m_axi_cap_raddr    (cap2),
    .m_axi_ref_raddr    (ref2),
    .tag_valid          (tv2),
    .tag_first          (tf2),
    .tag_last           (tl2),
    .tag_lag            (lag2),
    .sweep_done         (done2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model, advanced at every negedge after checking that cycle.
  typedef struct {
    int due;
    int first;
    int last;
    int lag;
  } tag_t;

  tag_t m_q[$];
  int   m_phase = 0;   // 0 idle, 1 issuing requests, 2 waiting for done
  int   m_k = 0;       // fires so far in this sweep
  int   m_done_at = 0;
  bit   mon_en = 1'b0;
  int   tag_cnt = 0;
  int   done_cnt = 0;
  int   last_done_cyc = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      check_eq("busy", busy, m_phase != 0);
      check_eq("rvalid", rvalid, m_phase == 1);
      if (m_phase == 1) begin
        check_eq("cap_raddr", cap_addr, m_k / REFL + m_k % REFL);
        check_eq("ref_raddr", ref_addr, m_k % REFL);
      end
      check_eq("sweep_done", sweep_done, (m_phase == 2) && (cyc == m_done_at));
      if (m_q.size() > 0 && m_q[0].due == cyc) begin
        check_eq("tag_valid", tag_valid, 1);
        check_eq("tag_first", tag_first, m_q[0].first);
        check_eq("tag_last", tag_last, m_q[0].last);
        check_eq("tag_lag", tag_lag, m_q[0].lag);
        void'(m_q.pop_front());
      end else begin
        check_eq("tag_valid_idle", tag_valid, 0);
      end
    end
    if (tag_valid) tag_cnt++;
    if (sweep_done) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
    if (rst || abort) begin
      m_phase = 0;
      m_k = 0;
      m_q.delete();
    end else begin
      case (m_phase)
        0: if (start) begin
          m_phase = 1;
          m_k = 0;
        end
        1: if (rready && tready) begin
          tag_t t;
          t.due   = cyc + LAT;
          t.first = (m_k % REFL == 0);
          t.last  = (m_k % REFL == REFL - 1);
          t.lag   = m_k / REFL;
          m_q.push_back(t);
          m_k++;
          if (m_k == TOTAL) begin
            m_phase = 2;
            m_done_at = cyc + LAT + 1;
          end
        end
        default: if (cyc == m_done_at) m_phase = 0;
      endcase
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_sweep(output int s_cyc);
    start = 1'b1;
    s_cyc = cyc;
    step();
    start = 1'b0;
  endtask

  // Length counts the start cycle as cycle 1.
  task automatic wait_done(input int s_cyc, input int exp_len, input string tag);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < 300) begin
      step();
      n++;
    end
    if (done_cnt == d0) check_eq({tag, "_timeout"}, 0, 1);
    else check_eq(tag, last_done_cyc - s_cyc + 1, exp_len);
  endtask

  task automatic wait_k(input int k);
    int n = 0;
    while (!(m_phase == 1 && m_k == k) && n < 300) begin
      step();
      n++;
    end
    if (n >= 300) check_eq("wait_fire_timeout", 0, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_rvalid"}, rvalid, 0);
    check_eq({tag, "_cap"}, cap_addr, 0);
    check_eq({tag, "_ref"}, ref_addr, 0);
    check_eq({tag, "_tags"}, {tag_valid, tag_first, tag_last, tag_lag}, 0);
    check_eq({tag, "_done"}, sweep_done, 0);
  endtask

  initial begin
    int s, t0, d0, nf2, nt2, dl2;
    repeat (3) step();
    check_all_zero("reset");
    rst = 1'b0;
    mon_en = 1'b1;
    step();

    // Unstalled sweep.
    t0 = tag_cnt;
    start_sweep(s);
    wait_done(s, TOTAL + LAT + 2, "len_basic");
    check_eq("tags_basic", tag_cnt - t0, TOTAL);
    step();

    // Frequency-shifter stall at lag 1, iter 2.
    t0 = tag_cnt;
    start_sweep(s);
    wait_k(6);
    tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("stall_cap", cap_addr, 3);
      check_eq("stall_ref", ref_addr, 2);
    end
    tready = 1'b1;
    wait_done(s, TOTAL + LAT + 2 + 3, "len_stall");
    check_eq("tags_stall", tag_cnt - t0, TOTAL);
    step();

    // Abort at fire 10.
    start_sweep(s);
    wait_k(10);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_eq("abort_rvalid", rvalid, 0);
    check_eq("abort_busy", busy, 0);
    t0 = tag_cnt;
    d0 = done_cnt;
    repeat (6) step();
    check_eq("abort_no_tags", tag_cnt - t0, 0);
    check_eq("abort_no_done", done_cnt - d0, 0);
    t0 = tag_cnt;
    start_sweep(s);
    wait_done(s, TOTAL + LAT + 2, "len_after_abort");
    check_eq("tags_after_abort", tag_cnt - t0, TOTAL);
    step();

    // Start pulses during SWEEP and DRAIN are ignored.
    start_sweep(s);
    wait_k(7);
    start = 1'b1;
    step();
    start = 1'b0;
    while (m_phase != 2 && cyc - s < 200) step();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(s, TOTAL + LAT + 2, "len_start_ignored");
    repeat (2) step();

    // abort + start together in IDLE.
    abort = 1'b1;
    start = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b0;
    check_eq("abort_start_busy", busy, 0);
    step();
    check_eq("abort_start_rvalid", rvalid, 0);

    // Reset mid-sweep.
    start_sweep(s);
    wait_k(5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_all_zero("midrst");
    start_sweep(s);
    wait_done(s, TOTAL + LAT + 2, "len_after_rst");
    step();

    // Random back-pressure, stray starts and occasional aborts.
    for (int it = 0; it < 6; it++) begin
      int n = 0;
      start_sweep(s);
      while (m_phase != 0 && n < 600) begin
        rready = ($urandom_range(0, 3) != 0);
        tready = ($urandom_range(0, 3) != 0);
        start  = ($urandom_range(0, 7) == 0);
        abort  = ($urandom_range(0, 199) == 0);
        step();
        n++;
      end
      rready = 1'b1;
      tready = 1'b1;
      start  = 1'b0;
      abort  = 1'b0;
      step();
      check_eq("rand_end_busy", busy, 0);
    end

    // Single-lag configuration.
    start2 = 1'b1;
    s = cyc;
    step();
    start2 = 1'b0;
    nf2 = 0;
    nt2 = 0;
    dl2 = 0;
    for (int j = 1; j <= 12; j++) begin
      if (rvalid2) nf2++;
      if (tv2) begin
        check_eq("d2_first", tf2, nt2 == 0);
        check_eq("d2_last", tl2, nt2 == 3);
        check_eq("d2_lag", lag2, 0);
        nt2++;
      end
      if (done2 && dl2 == 0) dl2 = cyc - s + 1;
      step();
    end
    check_eq("d2_fires", nf2, 4);
    check_eq("d2_tags", nt2, 4);
    check_eq("d2_len", dl2, 7);
    check_eq("d2_idle", busy2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
